// File: rtl/stream_crc_arbiter.sv
// stream_crc_arbiter
//   Merges two AXI-Stream-style requesters onto one output stream, one whole
//   frame at a time. Every beat of a frame is added into one shared 32-bit
//   accumulator. After the last beat, a trailer beat carries the accumulator
//   folded to 16 bits. The same folded value is then reported on crc_out.
//
// Handshake: a beat transfers on a rising clock edge when its valid and ready
//   are both 1. A source holds data/last stable while valid=1 and ready=0.
//   This block holds the trailer beat stable until m_tready=1.
//
// Ports
//   clock, rst            : single clock, synchronous active-high reset
//   s0_* / s1_*           : requester streams (tdata 32, tvalid, tlast, tready)
//   m_*                   : merged stream; tuser=1 marks the trailer beat,
//                           tid is the index of the source that owns the frame
//   crc_out/crc_valid/crc_src : folded checksum of the last completed frame,
//                           a one-cycle strobe for it, and its source index
//   dbg_state             : current FSM state (0 IDLE, 1 PASS, 2 TAIL)
module stream_crc_arbiter #(
  parameter bit PRIO_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] s0_tdata,
  input  logic        s0_tvalid,
  input  logic        s0_tlast,
  output logic        s0_tready,
  input  logic [31:0] s1_tdata,
  input  logic        s1_tvalid,
  input  logic        s1_tlast,
  output logic        s1_tready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        m_tid,
  input  logic        m_tready,
  output logic [15:0] crc_out,
  output logic        crc_valid,
  output logic        crc_src,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    TAIL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;       // requester served most recently
  logic [31:0] acc_q, acc_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic        crc_src_q, crc_src_d;
  logic        crc_valid_q, crc_valid_d;

  logic [31:0] g_data;
  logic        g_valid;
  logic        g_last;
  logic [15:0] fold;

  assign g_data  = grant_q ? s1_tdata  : s0_tdata;
  assign g_valid = grant_q ? s1_tvalid : s0_tvalid;
  assign g_last  = grant_q ? s1_tlast  : s0_tlast;
  // The 16-bit sum drops the carry out of bit 15.
  assign fold    = acc_q[31:16] + acc_q[15:0];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    acc_d       = acc_q;
    crc_out_d   = crc_out_q;
    crc_src_d   = crc_src_q;
    crc_valid_d = 1'b0;
    m_tdata     = 32'h0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    m_tid       = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          // On contention the requester not served last wins.
          grant_d = ~last_q;
          state_d = PASS;
        end else if (s0_tvalid) begin
          grant_d = 1'b0;
          state_d = PASS;
        end else if (s1_tvalid) begin
          grant_d = 1'b1;
          state_d = PASS;
        end
      end
      PASS: begin
        m_tdata  = g_data;
        m_tvalid = g_valid;
        m_tid    = grant_q;
        if (grant_q) s1_tready = m_tready;
        else         s0_tready = m_tready;
        if (g_valid && m_tready) begin
          acc_d = acc_q + g_data;
          if (g_last) state_d = TAIL;
        end
      end
      TAIL: begin
        m_tdata  = {16'h0, fold};
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        m_tid    = grant_q;
        if (m_tready) begin
          acc_d       = 32'h0;
          last_d      = grant_q;
          crc_out_d   = fold;
          crc_src_d   = grant_q;
          crc_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      // Start as if the other requester was served last, so the first
      // contention goes to PRIO_FIRST.
      last_q      <= ~PRIO_FIRST;
      acc_q       <= 32'h0;
      crc_out_q   <= 16'h0;
      crc_src_q   <= 1'b0;
      crc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      crc_out_q   <= crc_out_d;
      crc_src_q   <= crc_src_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign crc_out   = crc_out_q;
  assign crc_src   = crc_src_q;
  assign crc_valid = crc_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_crc_arbiter.sv
// Directed testbench for stream_crc_arbiter (PRIO_FIRST = 0).
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_stream_crc_arbiter;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s0_tdata = 32'h0;
  logic        s0_tvalid = 1'b0;
  logic        s0_tlast = 1'b0;
  logic        s0_tready;
  logic [31:0] s1_tdata = 32'h0;
  logic        s1_tvalid = 1'b0;
  logic        s1_tlast = 1'b0;
  logic        s1_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tid;
  logic        m_tready = 1'b1;
  logic [15:0] crc_out;
  logic        crc_valid;
  logic        crc_src;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected merged-stream beats {tuser, tlast, tid, tdata} and crc strobes {src, crc}.
  logic [34:0] exp_q[$];
  logic [16:0] crc_q[$];

  bit          stall_chk_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [34:0] prev_beat = '0;

  stream_crc_arbiter #(.PRIO_FIRST(1'b0)) dut (
    .clock(clock), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tid(m_tid), .m_tready(m_tready),
    .crc_out(crc_out), .crc_valid(crc_valid), .crc_src(crc_src), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic expect_beats(input bit src, input logic [31:0] b[$]);
    foreach (b[i]) exp_q.push_back({1'b0, 1'b0, src, b[i]});
  endtask

  // The trailer value is supplied already hand-folded.
  task automatic expect_frame(input bit src, input logic [31:0] b[$], input logic [15:0] trailer);
    expect_beats(src, b);
    exp_q.push_back({1'b1, 1'b1, src, 16'h0, trailer});
    crc_q.push_back({src, trailer});
  endtask

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_beat_unexpected observed=%h expected=none",
                   {m_tuser, m_tlast, m_tid, m_tdata});
        end else begin
          chk("m_beat", {m_tuser, m_tlast, m_tid, m_tdata}, exp_q.pop_front());
        end
      end
      if (crc_valid) begin
        if (crc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL crc_unexpected observed=%h expected=none", {crc_src, crc_out});
        end else begin
          chk("crc_strobe", {crc_src, crc_out}, crc_q.pop_front());
        end
      end
      if (stall_chk_en) begin
        if (prev_stall) chk("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tid, m_tdata},
                            {1'b1, prev_beat});
        if (!m_tready) chk("s_tready_gated", {s0_tready, s1_tready}, 2'b00);
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = {m_tuser, m_tlast, m_tid, m_tdata};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input bit src);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if ((src ? s1_tready : s0_tready) === 1'b1) break;
      n++;
      if (n >= 100) begin
        bound_fail(src ? "s1_ready_wait" : "s0_ready_wait");
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input bit src, input logic [31:0] b[$], input bit end_last);
    logic l;
    for (int i = 0; i < b.size(); i++) begin
      l = end_last && (i == b.size() - 1);
      if (src) begin s1_tdata = b[i]; s1_tvalid = 1'b1; s1_tlast = l; end
      else     begin s0_tdata = b[i]; s0_tvalid = 1'b1; s0_tlast = l; end
      wait_ready(src);
    end
    if (src) begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
    else     begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
  endtask

  // Returns the cycle count at which crc_valid was seen.
  task automatic wait_crc(output int seen);
    int n;
    n = 0;
    seen = -1;
    forever begin
      @(negedge clock);
      if (crc_valid === 1'b1) begin seen = cyc; break; end
      n++;
      if (n >= 100) begin bound_fail("crc_wait"); break; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() == 0 && crc_q.size() == 0) break;
      n++;
      if (n >= 200) begin bound_fail("scoreboard_drain"); break; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    int seen;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_m_flags", {m_tlast, m_tuser, m_tid}, 3'b000);
    chk("rst_s_tready", {s0_tready, s1_tready}, 2'b00);
    chk("rst_crc", {crc_valid, crc_src, crc_out}, 18'h0);
    @(posedge clock);
    #1;
    rst = 1'b0;

    // Stream check: two beats, trailer 0x000A, latency N+2 = 4
    expect_frame(1'b0, '{32'h00010002, 32'h00030004}, 16'h000A);
    c0 = cyc;
    send(1'b0, '{32'h00010002, 32'h00030004}, 1'b1);
    wait_crc(seen);
    chk("stream_latency", seen - c0, 4);
    @(negedge clock);
    chk("stream_crc_hold", {crc_valid, crc_src, crc_out}, {1'b0, 1'b0, 16'h000A});
    chk("stream_idle", {dbg_state, m_tvalid}, {2'd0, 1'b0});
    @(posedge clock);
    #1;

    // Fold-carry check, single-beat frame: latency N+2 = 3
    expect_frame(1'b0, '{32'hFFFF0001}, 16'h0000);
    c0 = cyc;
    send(1'b0, '{32'hFFFF0001}, 1'b1);
    wait_crc(seen);
    chk("single_latency", seen - c0, 3);
    chk("fold_crc_out", crc_out, 16'h0000);

    // Wrap check: 0xFFFFFFFF + 2 wraps to 1
    expect_frame(1'b0, '{32'hFFFFFFFF, 32'h00000002}, 16'h0001);
    send(1'b0, '{32'hFFFFFFFF, 32'h00000002}, 1'b1);
    wait_crc(seen);
    @(negedge clock);
    chk("wrap_crc_hold", {crc_src, crc_out}, {1'b0, 16'h0001});
    @(posedge clock);
    #1;

    // Reset returns crc outputs and last-served to their initial values
    pulse_reset();
    @(negedge clock);
    chk("rst2_crc", {crc_valid, crc_src, crc_out}, 18'h0);
    @(posedge clock);
    #1;

    // Contention: both continuously valid, order s0,s1,s0,s1
    expect_frame(1'b0, '{32'h1, 32'h2, 32'h3}, 16'h0006);
    expect_frame(1'b1, '{32'h10, 32'h20, 32'h30}, 16'h0060);
    expect_frame(1'b0, '{32'h100, 32'h200, 32'h300}, 16'h0600);
    expect_frame(1'b1, '{32'h1000, 32'h2000, 32'h3000}, 16'h6000);
    fork
      begin
        send(1'b0, '{32'h1, 32'h2, 32'h3}, 1'b1);
        send(1'b0, '{32'h100, 32'h200, 32'h300}, 1'b1);
      end
      begin
        send(1'b1, '{32'h10, 32'h20, 32'h30}, 1'b1);
        send(1'b1, '{32'h1000, 32'h2000, 32'h3000}, 1'b1);
      end
    join
    wait_empty();
    @(negedge clock);
    chk("contend_crc_hold", {crc_src, crc_out}, {1'b1, 16'h6000});
    @(posedge clock);
    #1;

    // Backpressure: m_tready toggles 1,0,1,0 over a 4-beat frame
    expect_frame(1'b1, '{32'h11, 32'h22, 32'h33, 32'h44}, 16'h00AA);
    stall_chk_en = 1'b1;
    fork
      send(1'b1, '{32'h11, 32'h22, 32'h33, 32'h44}, 1'b1);
      begin
        for (int k = 0; k < 24; k++) begin
          @(posedge clock);
          #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    wait_empty();
    stall_chk_en = 1'b0;

    // Reset mid-frame: 2 of 4 beats, then one reset cycle
    expect_beats(1'b0, '{32'h7, 32'h8});
    send(1'b0, '{32'h7, 32'h8}, 1'b0);
    chk("midframe_in_pass", dbg_state, 2'd1);
    pulse_reset();
    @(negedge clock);
    chk("midframe_after_rst_state", dbg_state, 2'd0);
    chk("midframe_after_rst_valid", m_tvalid, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    expect_frame(1'b0, '{32'h00000005}, 16'h0005);
    send(1'b0, '{32'h00000005}, 1'b1);
    wait_crc(seen);
    chk("midframe_next_crc", {crc_src, crc_out}, {1'b0, 16'h0005});

    wait_empty();
    chk("exp_q_left", exp_q.size(), 0);
    chk("crc_q_left", crc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
